// File: rtl/arbitro_alu.sv
// Round-robin arbiter that lets two requesters share one external ALU.
// Rejects illegal opcodes and division/modulo by zero without touching the ALU.
module arbitro_alu #(
  parameter int unsigned ANCHO = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           valido_0,
  input  logic           valido_1,
  output logic           listo_0,
  output logic           listo_1,
  input  logic [ANCHO:0] opA_0,
  input  logic [ANCHO:0] opB_0,
  input  logic [3:0]     sel_0,
  input  logic [ANCHO:0] opA_1,
  input  logic [ANCHO:0] opB_1,
  input  logic [3:0]     sel_1,
  output logic [ANCHO:0] alu_operandoA,
  output logic [ANCHO:0] alu_operandoB,
  output logic [3:0]     alu_seleccion,
  input  logic [ANCHO:0] alu_resultado,
  input  logic [3:0]     alu_banderas,
  output logic           resp_valido,
  input  logic           resp_listo,
  output logic           resp_id,
  output logic [ANCHO:0] resp_resultado,
  output logic [3:0]     resp_banderas,
  output logic           resp_error
);

  localparam logic [3:0] OpDiv = 4'd3;
  localparam logic [3:0] OpMod = 4'd4;
  localparam logic [3:0] OpMax = 4'd9;

  typedef enum logic [1:0] {StLibre, StEjecuta, StResponde} estado_t;

  estado_t        r_estado;
  logic           r_ultimo;
  logic [ANCHO:0] r_alu_a;
  logic [ANCHO:0] r_alu_b;
  logic [3:0]     r_alu_sel;
  logic           r_resp_valido;
  logic           r_resp_id;
  logic [ANCHO:0] r_resp_res;
  logic [3:0]     r_resp_flg;
  logic           r_resp_err;

  logic           w_libre;
  logic           w_gnt1;
  logic           w_acepta;
  logic [ANCHO:0] w_opa;
  logic [ANCHO:0] w_opb;
  logic [3:0]     w_sel;
  logic           w_rechazo;

  // Reset gates the handshake so nothing is offered while rst_n is low.
  assign w_libre = (r_estado == StLibre) && rst_n;

  always_comb begin
    w_gnt1 = valido_1;
    if (valido_0 && valido_1) begin
      w_gnt1 = ~r_ultimo;
    end
  end

  assign listo_0  = w_libre && valido_0 && !w_gnt1;
  assign listo_1  = w_libre && valido_1 && w_gnt1;
  assign w_acepta = listo_0 || listo_1;

  assign w_opa     = w_gnt1 ? opA_1 : opA_0;
  assign w_opb     = w_gnt1 ? opB_1 : opB_0;
  assign w_sel     = w_gnt1 ? sel_1 : sel_0;
  assign w_rechazo = (w_sel > OpMax) || (((w_sel == OpDiv) || (w_sel == OpMod)) && (w_opb == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado      <= StLibre;
      r_ultimo      <= 1'b1;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_sel     <= '0;
      r_resp_valido <= 1'b0;
      r_resp_id     <= 1'b0;
      r_resp_res    <= '0;
      r_resp_flg    <= '0;
      r_resp_err    <= 1'b0;
    end else begin
      unique case (r_estado)
        StLibre: begin
          if (w_acepta) begin
            r_resp_id <= w_gnt1;
            r_ultimo  <= w_gnt1;
            if (w_rechazo) begin
              r_resp_err    <= 1'b1;
              r_resp_res    <= '0;
              r_resp_flg    <= '0;
              r_resp_valido <= 1'b1;
              r_estado      <= StResponde;
            end else begin
              r_alu_a   <= w_opa;
              r_alu_b   <= w_opb;
              r_alu_sel <= w_sel;
              r_estado  <= StEjecuta;
            end
          end
        end
        StEjecuta: begin
          r_resp_res    <= alu_resultado;
          r_resp_flg    <= alu_banderas;
          r_resp_err    <= 1'b0;
          r_resp_valido <= 1'b1;
          r_estado      <= StResponde;
        end
        StResponde: begin
          if (resp_listo) begin
            r_resp_valido <= 1'b0;
            r_estado      <= StLibre;
          end
        end
        default: begin
          r_resp_valido <= 1'b0;
          r_estado      <= StLibre;
        end
      endcase
    end
  end

  assign alu_operandoA  = r_alu_a;
  assign alu_operandoB  = r_alu_b;
  assign alu_seleccion  = r_alu_sel;
  assign resp_valido    = r_resp_valido;
  assign resp_id        = r_resp_id;
  assign resp_resultado = r_resp_res;
  assign resp_banderas  = r_resp_flg;
  assign resp_error     = r_resp_err;

endmodule

// File: tb/tb_arbitro_alu.sv
// Bench for arbitro_alu: behavioural ALU stub, transaction-level model and a
// queue-based scoreboard drained by an independent response monitor.
module tb_arbitro_alu;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valido_0 = 1'b0, valido_1 = 1'b0;
  logic       listo_0, listo_1;
  logic [3:0] opA_0 = '0, opB_0 = '0, sel_0 = '0;
  logic [3:0] opA_1 = '0, opB_1 = '0, sel_1 = '0;
  logic [3:0] alu_operandoA, alu_operandoB, alu_seleccion;
  logic [3:0] alu_resultado, alu_banderas;
  logic       resp_valido;
  logic       resp_listo = 1'b0;
  logic       resp_id;
  logic [3:0] resp_resultado, resp_banderas;
  logic       resp_error;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int lmode    = 2;  // 0 random, 1 hold off, 2 always take

  typedef struct {
    logic       id;
    logic [3:0] res;
    logic [3:0] flg;
    logic       err;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    int         t;
  } item_t;

  item_t sb_q[$];

  // Transaction-level model state
  logic       m_busy   = 1'b0;
  int         m_resp_at = 0;
  logic       m_ultimo = 1'b1;
  logic [3:0] m_a = '0, m_b = '0, m_s = '0;

  arbitro_alu #(.ANCHO(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valido_0       (valido_0),
    .valido_1       (valido_1),
    .listo_0        (listo_0),
    .listo_1        (listo_1),
    .opA_0          (opA_0),
    .opB_0          (opB_0),
    .sel_0          (sel_0),
    .opA_1          (opA_1),
    .opB_1          (opB_1),
    .sel_1          (sel_1),
    .alu_operandoA  (alu_operandoA),
    .alu_operandoB  (alu_operandoB),
    .alu_seleccion  (alu_seleccion),
    .alu_resultado  (alu_resultado),
    .alu_banderas   (alu_banderas),
    .resp_valido    (resp_valido),
    .resp_listo     (resp_listo),
    .resp_id        (resp_id),
    .resp_resultado (resp_resultado),
    .resp_banderas  (resp_banderas),
    .resp_error     (resp_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Returns {N,Z,C,V, result}
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] s);
    int x;
    logic [3:0] r;
    logic c, v;
    x = 0; c = 1'b0; v = 1'b0;
    case (s)
      4'd0: begin x = int'(a) + int'(b); c = x > 15;
              v = (a[3] == b[3]) && (x[3] != a[3]); end
      4'd1: begin x = int'(a) - int'(b); c = a < b;
              v = (a[3] != b[3]) && (x[3] != a[3]); end
      4'd2: begin x = int'(a) * int'(b); c = x > 15; end
      4'd3: x = (b == 0) ? 0 : int'(a) / int'(b);
      4'd4: x = (b == 0) ? 0 : int'(a) % int'(b);
      4'd5: x = int'(a & b);
      4'd6: x = int'(a | b);
      4'd7: x = int'(a ^ b);
      4'd8: x = int'(a) << b;
      4'd9: x = int'(a) >> b;
      default: x = 0;
    endcase
    r = x[3:0];
    return {r[3], r == 4'd0, c, v, r};
  endfunction

  assign {alu_banderas, alu_resultado} = alu_fn(alu_operandoA, alu_operandoB, alu_seleccion);

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  // One cycle of requester stimulus; checks the handshake against the model.
  task automatic step(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                      input logic [3:0] s0, input logic v1, input logic [3:0] a1,
                      input logic [3:0] b1, input logic [3:0] s1,
                      output logic acc0, output logic acc1);
    logic g1, idle, rej;
    logic [3:0] a, b, s;
    item_t it;
    @(negedge clk);
    valido_0 = v0; opA_0 = a0; opB_0 = b0; sel_0 = s0;
    valido_1 = v1; opA_1 = a1; opB_1 = b1; sel_1 = s1;
    #4;
    g1   = (v0 && v1) ? !m_ultimo : v1;
    idle = !m_busy && rst_n;
    acc0 = idle && v0 && !g1;
    acc1 = idle && v1 && g1;
    chk("listo_0", {31'd0, listo_0}, {31'd0, acc0});
    chk("listo_1", {31'd0, listo_1}, {31'd0, acc1});
    if (m_busy && cyc >= m_resp_at && resp_listo) m_busy = 1'b0;
    if (acc0 || acc1) begin
      a = acc1 ? a1 : a0;
      b = acc1 ? b1 : b0;
      s = acc1 ? s1 : s0;
      rej = (s > 4'd9) || ((s == 4'd3 || s == 4'd4) && b == 4'd0);
      it.id = acc1;
      it.err = rej;
      {it.flg, it.res} = rej ? 8'd0 : alu_fn(a, b, s);
      if (!rej) begin m_a = a; m_b = b; m_s = s; end
      it.a = m_a; it.b = m_b; it.s = m_s;
      m_resp_at = cyc + (rej ? 1 : 2);
      it.t = m_resp_at;
      sb_q.push_back(it);
      m_busy = 1'b1;
      m_ultimo = acc1;
    end
  endtask

  task automatic idle_steps(input int n);
    logic x0, x1;
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, x0, x1);
  endtask

  task automatic drain();
    int k;
    lmode = 2;
    k = 0;
    while (m_busy && k < 20) begin idle_steps(1); k++; end
    idle_steps(1);
    chk("drain_busy", {31'd0, m_busy}, 32'd0);
    chk("drain_queue", sb_q.size(), 32'd0);
  endtask

  // Response monitor
  initial begin : monitor
    logic  in_resp;
    item_t cur;
    in_resp = 1'b0;
    forever begin
      @(negedge clk);
      case (lmode)
        0: resp_listo = ($urandom_range(0, 9) < 6);
        1: resp_listo = 1'b0;
        default: resp_listo = 1'b1;
      endcase
      #4;
      if (!rst_n) begin
        in_resp = 1'b0;
      end else if (resp_valido) begin
        if (!in_resp) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_resp: got resp_valido=1 expected no response (t=%0t)",
                     $time);
          end else begin
            cur = sb_q.pop_front();
            chk("resp_latency", cyc, cur.t);
            chk("alu_operandoA", {28'd0, alu_operandoA}, {28'd0, cur.a});
            chk("alu_operandoB", {28'd0, alu_operandoB}, {28'd0, cur.b});
            chk("alu_seleccion", {28'd0, alu_seleccion}, {28'd0, cur.s});
          end
          in_resp = 1'b1;
        end
        chk("resp_id", {31'd0, resp_id}, {31'd0, cur.id});
        chk("resp_resultado", {28'd0, resp_resultado}, {28'd0, cur.res});
        chk("resp_banderas", {28'd0, resp_banderas}, {28'd0, cur.flg});
        chk("resp_error", {31'd0, resp_error}, {31'd0, cur.err});
        if (resp_listo) in_resp = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic x0, x1;
    logic rv [2];
    logic [3:0] ra [2], rb [2], rs [2];

    // Reset with requester 0 asserting
    valido_0 = 1'b1; opA_0 = 4'd3; opB_0 = 4'd4; sel_0 = 4'd0;
    repeat (3) @(negedge clk);
    #4;
    chk("rst_listo_0", {31'd0, listo_0}, 32'd0);
    chk("rst_listo_1", {31'd0, listo_1}, 32'd0);
    chk("rst_outputs", {8'd0, alu_operandoA, alu_operandoB, alu_seleccion, resp_valido,
                        resp_id, resp_resultado, resp_banderas, resp_error}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single command 3+4
    step(1'b1, 4'd3, 4'd4, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, x0, x1);
    idle_steps(1);
    chk("single_alu_a", {28'd0, alu_operandoA}, 32'd3);
    chk("single_alu_b", {28'd0, alu_operandoB}, 32'd4);
    idle_steps(2);

    // Round robin with both always valid
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)), 4'($urandom_range(0, 9)),
           1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)), 4'($urandom_range(0, 9)),
           x0, x1);
    end
    drain();

    // Rejections
    step(1'b1, 4'd5, 4'd2, 4'd12, 1'b0, 4'd0, 4'd0, 4'd0, x0, x1);
    idle_steps(2);
    step(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd9, 4'd0, 4'd3, x0, x1);
    idle_steps(2);
    step(1'b1, 4'd9, 4'd0, 4'd4, 1'b0, 4'd0, 4'd0, 4'd0, x0, x1);
    drain();

    // Backpressure
    lmode = 1;
    step(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd6, 4'd3, 4'd2, x0, x1);
    for (int i = 0; i < 6; i++) step(1'b1, 4'd1, 4'd1, 4'd0, 1'b1, 4'd2, 4'd2, 4'd1, x0, x1);
    lmode = 2;
    for (int i = 0; i < 4; i++) step(1'b1, 4'd1, 4'd1, 4'd0, 1'b1, 4'd2, 4'd2, 4'd1, x0, x1);
    drain();

    // Randomized traffic with held requests and random backpressure
    lmode = 0;
    rv[0] = 1'b0; rv[1] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!rv[r] && $urandom_range(0, 1) == 1) begin
          rv[r] = 1'b1;
          ra[r] = 4'($urandom_range(0, 15));
          rb[r] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
          rs[r] = 4'($urandom_range(0, 15));
        end
      end
      step(rv[0], ra[0], rb[0], rs[0], rv[1], ra[1], rb[1], rs[1], x0, x1);
      if (x0) rv[0] = 1'b0;
      if (x1) rv[1] = 1'b0;
    end
    drain();

    // Reset while the command is executing
    step(1'b1, 4'd2, 4'd3, 4'd2, 1'b1, 4'd4, 4'd4, 4'd0, x0, x1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    chk("midrst_resp_valido", {31'd0, resp_valido}, 32'd0);
    chk("midrst_listo_0", {31'd0, listo_0}, 32'd0);
    sb_q.delete();
    m_busy = 1'b0; m_ultimo = 1'b1;
    m_a = '0; m_b = '0; m_s = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_steps(4);
    step(1'b1, 4'd1, 4'd2, 4'd6, 1'b1, 4'd3, 4'd1, 4'd7, x0, x1);
    chk("post_rst_tie", {30'd0, x1, x0}, 32'd1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
